// File: rtl/ram_port_initiator.sv
// Request/response front end for one port of a dual-port block RAM.
// Tracks the RAM's fixed read latency and buffers read data in a credit-managed response FIFO.
module ram_port_initiator #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RESP_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    output logic [$clog2(RESP_DEPTH):0]   rd_pending
);

    localparam int unsigned PtrW = $clog2(RESP_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Depth = CntW'(RESP_DEPTH);

    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [PtrW-1:0]         wptr_q, wptr_d;
    logic [PtrW-1:0]         rptr_q, rptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [CntW-1:0]         pend_q, pend_d;
    logic [DATA_WIDTH-1:0]   mem_q [RESP_DEPTH];

    logic rd_accept;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    // Credits cover both in-flight reads and queued responses, so the FIFO can never overflow.
    assign req_ready  = !rst && (pend_q < Depth);
    assign ram_we     = req_valid && req_ready && req_we;
    assign ram_addr   = req_addr;
    assign ram_din    = req_wdata;
    assign rd_accept  = req_valid && req_ready && !req_we;

    assign push       = pipe_q[READ_LATENCY-1];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == Depth);
    assign rsp_valid  = !fifo_empty;
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_rdata  = rsp_valid ? mem_q[rptr_q] : '0;
    assign rd_pending = pend_q;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = rd_accept;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        wptr_d = wptr_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end

        rptr_d = rptr_q;
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        pend_d = pend_q;
        unique case ({rd_accept, pop})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            pipe_q  <= pipe_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    // Storage needs no reset: rsp_rdata is gated by rsp_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= ram_dout;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full))
        else $error("response FIFO push while full");

endmodule

// File: tb/tb_ram_port_initiator.sv
// Bench for ram_port_initiator: two instances (read latency 1 and 2) with behavioural RAMs,
// checked every cycle against a queue-based model of request/response ordering and timing.
module tb_ram_port_initiator;

    localparam int unsigned Depth = 4;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we    [2];
    logic [8:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_rdata [2];
    logic       ram_we    [2];
    logic [8:0] ram_addr  [2];
    logic [7:0] ram_din   [2];
    logic [7:0] ram_dout  [2];
    logic [2:0] rd_pending[2];
    bit         rand_rdy  [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned RL = g + 1;

        exp_t       q[$];
        logic [7:0] ram  [512];
        logic [7:0] rmem [512];
        logic [7:0] d1;
        logic [7:0] d2;

        ram_port_initiator #(
            .DATA_WIDTH  (8),
            .ADDR_WIDTH  (9),
            .READ_LATENCY(RL),
            .RESP_DEPTH  (Depth)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_din   (ram_din[g]),
            .ram_dout  (ram_dout[g]),
            .rd_pending(rd_pending[g])
        );

        // Read-first block RAM port, optional output register.
        always @(posedge clk) begin
            if (ram_we[g]) ram[ram_addr[g]] <= ram_din[g];
            d1 <= ram[ram_addr[g]];
            d2 <= d1;
        end
        assign ram_dout[g] = (RL == 1) ? d1 : d2;

        always @(negedge clk) begin : mon
            bit   exp_v;
            exp_t e;
            if (rst) begin
                q.delete();
                chk($sformatf("d%0d_rst_req_ready", g), req_ready[g], 0);
                chk($sformatf("d%0d_rst_rsp_valid", g), rsp_valid[g], 0);
                chk($sformatf("d%0d_rst_rd_pending", g), rd_pending[g], 0);
                chk($sformatf("d%0d_rst_rsp_rdata", g), rsp_rdata[g], 0);
                chk($sformatf("d%0d_rst_ram_we", g), ram_we[g], 0);
            end else begin
                chk($sformatf("d%0d_req_ready", g), req_ready[g], q.size() < Depth);
                chk($sformatf("d%0d_rd_pending", g), rd_pending[g], q.size());
                exp_v = (q.size() != 0) && (q[0].due <= cyc);
                chk($sformatf("d%0d_rsp_valid", g), rsp_valid[g], exp_v);
                if (exp_v) chk($sformatf("d%0d_rsp_rdata", g), rsp_rdata[g], q[0].data);
                chk($sformatf("d%0d_ram_addr", g), ram_addr[g], req_addr[g]);
                chk($sformatf("d%0d_ram_we", g), ram_we[g],
                    req_valid[g] && (q.size() < Depth) && req_we[g]);
                if (exp_v && rsp_ready[g]) void'(q.pop_front());
                if (req_valid[g] && req_ready[g]) begin
                    if (req_we[g]) begin
                        chk($sformatf("d%0d_ram_din", g), ram_din[g], req_wdata[g]);
                        rmem[req_addr[g]] = req_wdata[g];
                    end else begin
                        e.data = rmem[req_addr[g]];
                        e.due  = cyc + RL + 1;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rand_rdy[d]) rsp_ready[d] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_req(input int d, input bit we, input logic [8:0] a, input logic [7:0] wd);
        int n = 0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        while (!req_ready[d] && n < 50) begin
            tick();
            n++;
        end
        chk($sformatf("d%0d_accept_in_time", d), n < 50, 1);
        tick();
        req_valid[d] = 1'b0;
    endtask

    initial begin
        int n;
        int stall;
        int n_rsp;
        int n_acc;
        int n_stale;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b1;
            rand_rdy[d]  = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int d = 0; d < 2; d++) begin
            // Write then read back, measuring accept-to-response latency.
            do_req(d, 1'b1, 9'h010, 8'hA5);
            do_req(d, 1'b0, 9'h010, 8'h00);
            n = 0;
            while (!rsp_valid[d] && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("d%0d_read_latency", d), n + 1, d + 2);
            chk($sformatf("d%0d_read_data", d), rsp_rdata[d], 8'hA5);
            tick();

            for (int i = 0; i < 64; i++) do_req(d, 1'b1, 9'(i), 8'(i));

            // Back-to-back stream of reads.
            stall = 0;
            n_rsp = 0;
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b0;
            for (int i = 0; i < 64; i++) begin
                req_addr[d] = 9'(i);
                n = 0;
                while (!req_ready[d] && n < 20) begin
                    stall++;
                    if (rsp_valid[d]) n_rsp++;
                    tick();
                    n++;
                end
                if (rsp_valid[d]) n_rsp++;
                tick();
            end
            req_valid[d] = 1'b0;
            for (int k = 0; k <= d + 1; k++) begin
                if (rsp_valid[d]) n_rsp++;
                tick();
            end
            chk($sformatf("d%0d_stream_stalls", d), stall, 0);
            chk($sformatf("d%0d_stream_responses", d), n_rsp, 64);

            // Fill credits with the response channel blocked.
            rsp_ready[d] = 1'b0;
            n_acc = 0;
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b0;
            for (int k = 0; k < 12; k++) begin
                req_addr[d] = 9'(k + 20);
                if (req_ready[d]) n_acc++;
                tick();
            end
            req_valid[d] = 1'b0;
            chk($sformatf("d%0d_fill_accepted", d), n_acc, Depth);
            chk($sformatf("d%0d_fill_pending", d), rd_pending[d], Depth);
            chk($sformatf("d%0d_fill_ready_low", d), req_ready[d], 0);
            rsp_ready[d] = 1'b1;
            for (int k = 0; k < 10; k++) tick();
            chk($sformatf("d%0d_drain_pending", d), rd_pending[d], 0);

            // Alternate write/read around the top/bottom address with random backpressure.
            rand_rdy[d] = 1'b1;
            for (int k = 0; k < 16; k++) begin
                logic [8:0] a;
                a = (k % 2 == 1) ? 9'h1FF : 9'h000;
                do_req(d, 1'b1, a, 8'($urandom));
                do_req(d, 1'b0, a, 8'h00);
            end
            rand_rdy[d]  = 1'b0;
            rsp_ready[d] = 1'b1;
            for (int k = 0; k < 10; k++) tick();
            chk($sformatf("d%0d_alt_pending", d), rd_pending[d], 0);
        end

        // Random traffic on both ports at once.
        for (int k = 0; k < 300; k++) begin
            for (int d = 0; d < 2; d++) begin
                req_valid[d] = 1'($urandom_range(0, 1));
                req_we[d]    = 1'($urandom_range(0, 1));
                req_addr[d]  = 9'($urandom_range(0, 63));
                req_wdata[d] = 8'($urandom);
                rsp_ready[d] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        for (int k = 0; k < 10; k++) tick();

        // Reset with reads in flight and queued.
        for (int d = 0; d < 2; d++) rsp_ready[d] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                req_valid[d] = 1'b1;
                req_we[d]    = 1'b0;
                req_addr[d]  = 9'(k);
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            chk($sformatf("d%0d_pre_rst_pending", d), rd_pending[d], Depth);
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_async_rst_ready", d), req_ready[d], 0);
            chk($sformatf("d%0d_async_rst_valid", d), rsp_valid[d], 0);
            chk($sformatf("d%0d_async_rst_pending", d), rd_pending[d], 0);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) rsp_ready[d] = 1'b1;
        n_stale = 0;
        for (int k = 0; k < 10; k++) begin
            for (int d = 0; d < 2; d++) if (rsp_valid[d]) n_stale++;
            tick();
        end
        chk("stale_responses", n_stale, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
